shift_rotate_seq: RTL and testbench

Sequential, parametrised successor to the one-step rotator. It loads an N-bit operand and applies AMT single-bit steps, one per clock. Each step is a rotate, logical shift, arithmetic shift or rotate-through-carry, to the left or right. A START/BUSY/DONE handshake frames each operation. Used as a multi-cycle shift unit in datapath exercises; it replaces chains of combinational rotators.

---
 rtl/shift_rotate_pkg.sv | 23 ++
 rtl/shift_step.sv | 46 ++++
 rtl/shift_rotate_seq.sv | 91 +++++++++
 tb/tb_shift_rotate_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/shift_rotate_pkg.sv
// Shared types for the sequential shift/rotate unit.
package shift_rotate_pkg;

  // Step operation; encoding matches the MODE input.
  typedef enum logic [1:0] {
    ROT = 2'b00,
    LSH = 2'b01,
    ASH = 2'b10,
    RCC = 2'b11
  } mode_t;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Direction encoding of DIR.
  localparam logic DirLeft  = 1'b0;
  localparam logic DirRight = 1'b1;

endpackage

// File: rtl/shift_step.sv
// One-step shift/rotate unit: computes the next working value and carry
// for a single left or right step in any of the four modes.
module shift_step
  import shift_rotate_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] i_y,
  input  logic         i_c,
  input  logic         i_dir,
  input  logic [1:0]   i_mode,
  output logic [N-1:0] o_y,
  output logic         o_c
);

  logic w_fill;

  // Select the bit shifted in, then assemble the stepped word and carry-out.
  always_comb begin
    w_fill = 1'b0;
    o_y    = i_y;
    o_c    = i_c;
    if (i_dir == DirRight) begin
      unique case (mode_t'(i_mode))
        ROT:     w_fill = i_y[0];
        LSH:     w_fill = 1'b0;
        ASH:     w_fill = i_y[N-1];
        RCC:     w_fill = i_c;
        default: w_fill = 1'b0;
      endcase
      o_y = {w_fill, i_y[N-1:1]};
      o_c = i_y[0];
    end else begin
      unique case (mode_t'(i_mode))
        ROT:     w_fill = i_y[N-1];
        LSH:     w_fill = 1'b0;
        ASH:     w_fill = 1'b0;  // arithmetic left is the same as logical left
        RCC:     w_fill = i_c;
        default: w_fill = 1'b0;
      endcase
      o_y = {i_y[N-2:0], w_fill};
      o_c = i_y[N-1];
    end
  end

endmodule

// File: rtl/shift_rotate_seq.sv
// Sequential shift/rotate unit: loads an N-bit operand and applies up to N
// single-bit steps, one per clock, framed by a START/BUSY/DONE handshake.
module shift_rotate_seq
  import shift_rotate_pkg::*;
#(
  parameter int unsigned N = 8,
  localparam int unsigned AW = $clog2(N) + 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [N-1:0]  i_x,
  input  logic          i_dir,
  input  logic [1:0]    i_mode,
  input  logic [AW-1:0] i_amt,
  input  logic          i_cin,
  output logic [N-1:0]  o_y,
  output logic          o_c,
  output logic          o_busy,
  output logic          o_done
);

  state_t        r_state;
  logic [N-1:0]  r_y;
  logic          r_c;
  logic          r_dir;
  mode_t         r_mode;
  logic [AW-1:0] r_cnt;

  logic [AW-1:0] w_amt_sat;
  logic [N-1:0]  w_step_y;
  logic          w_step_c;
  logic          w_accept;

  // Amounts beyond N are clamped so RCC can never wrap the N+1 bit ring.
  assign w_amt_sat = (i_amt > AW'(N)) ? AW'(N) : i_amt;
  assign w_accept  = i_start && (r_state != SHIFT);

  shift_step #(
    .N (N)
  ) u_step (
    .i_y    (r_y),
    .i_c    (r_c),
    .i_dir  (r_dir),
    .i_mode (r_mode),
    .o_y    (w_step_y),
    .o_c    (w_step_c)
  );

  // Controller, step counter and working registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_y     <= '0;
      r_c     <= 1'b0;
      r_dir   <= 1'b0;
      r_mode  <= ROT;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_y     <= i_x;
            r_c     <= (mode_t'(i_mode) == RCC) ? i_cin : 1'b0;
            r_dir   <= i_dir;
            r_mode  <= mode_t'(i_mode);
            r_cnt   <= w_amt_sat;
            r_state <= (w_amt_sat != '0) ? SHIFT : DONE;
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          r_y   <= w_step_y;
          r_c   <= w_step_c;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == AW'(1)) begin
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_y    = r_y;
  assign o_c    = r_c;
  assign o_busy = (r_state == SHIFT);
  assign o_done = (r_state == DONE);

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Directed bench for shift_rotate_seq with N=8: a vector table of complete
// operations plus hand-written sequences for the handshake corner cases.
module tb_shift_rotate_seq;

  localparam int N  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [N-1:0]  x;
  logic          dir;
  logic [1:0]    mode;
  logic [AW-1:0] amt;
  logic          cin;
  logic [N-1:0]  y;
  logic          c;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  shift_rotate_seq #(
    .N (N)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .i_start (start),
    .i_x     (x),
    .i_dir   (dir),
    .i_mode  (mode),
    .i_amt   (amt),
    .i_cin   (cin),
    .o_y     (y),
    .o_c     (c),
    .o_busy  (busy),
    .o_done  (done)
  );

  typedef struct {
    string          name;
    logic [N-1:0]   x;
    logic           dir;
    logic [1:0]     mode;
    logic [AW-1:0]  amt;
    logic           cin;
    logic [N-1:0]   exp_y;
    logic           exp_c;
    int             exp_busy;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one operation (START high for one edge); inputs driven at negedge.
  task automatic launch(input logic [N-1:0] vx, input logic vdir, input logic [1:0] vmode,
                        input logic [AW-1:0] vamt, input logic vcin);
    x     = vx;
    dir   = vdir;
    mode  = vmode;
    amt   = vamt;
    cin   = vcin;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for DONE, counting BUSY cycles seen on the way.
  task automatic wait_done(output int nbusy, output bit seen);
    nbusy = 0;
    seen  = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nbusy++;
      @(negedge clk);
    end
  endtask

  initial begin
    int   nb;
    bit   seen;
    logic any_done;

    vecs[0]  = '{"rot_r_96_3",   8'h96, 1'b1, 2'b00, 4'd3,  1'b0, 8'hD2, 1'b1, 3};
    vecs[1]  = '{"ash_r_a0_2",   8'hA0, 1'b1, 2'b10, 4'd2,  1'b0, 8'hE8, 1'b0, 2};
    vecs[2]  = '{"lsh_l_81_1",   8'h81, 1'b0, 2'b01, 4'd1,  1'b0, 8'h02, 1'b1, 1};
    vecs[3]  = '{"rcc_l_80_1",   8'h80, 1'b0, 2'b11, 4'd1,  1'b0, 8'h00, 1'b1, 1};
    vecs[4]  = '{"rcc_l_80_2",   8'h80, 1'b0, 2'b11, 4'd2,  1'b0, 8'h01, 1'b0, 2};
    vecs[5]  = '{"amt0_5a",      8'h5A, 1'b1, 2'b00, 4'd0,  1'b0, 8'h5A, 1'b0, 0};
    vecs[6]  = '{"amt0_rcc_cin", 8'h5A, 1'b0, 2'b11, 4'd0,  1'b1, 8'h5A, 1'b1, 0};
    vecs[7]  = '{"rot_r_5a_8",   8'h5A, 1'b1, 2'b00, 4'd8,  1'b0, 8'h5A, 1'b0, 8};
    vecs[8]  = '{"rot_r_96_15",  8'h96, 1'b1, 2'b00, 4'd15, 1'b0, 8'h96, 1'b1, 8};
    vecs[9]  = '{"lsh_l_ff_8",   8'hFF, 1'b0, 2'b01, 4'd8,  1'b0, 8'h00, 1'b1, 8};
    vecs[10] = '{"ash_r_96_8",   8'h96, 1'b1, 2'b10, 4'd8,  1'b0, 8'hFF, 1'b1, 8};
    vecs[11] = '{"rcc_r_01_1",   8'h01, 1'b1, 2'b11, 4'd1,  1'b1, 8'h80, 1'b1, 1};
    vecs[12] = '{"rcc_l_5a_8",   8'h5A, 1'b0, 2'b11, 4'd8,  1'b1, 8'hAD, 1'b0, 8};
    vecs[13] = '{"rot_l_96_3",   8'h96, 1'b0, 2'b00, 4'd3,  1'b0, 8'hB4, 1'b0, 3};

    reset = 1'b1;
    start = 1'b0;
    x     = '0;
    dir   = 1'b0;
    mode  = 2'b00;
    amt   = '0;
    cin   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_y", 32'(y), 32'h0);
    check("reset_c", 32'(c), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven operations.
    for (int i = 0; i < 14; i++) begin
      launch(vecs[i].x, vecs[i].dir, vecs[i].mode, vecs[i].amt, vecs[i].cin);
      wait_done(nb, seen);
      check({vecs[i].name, "_done_seen"}, 32'(seen), 32'h1);
      check({vecs[i].name, "_busy_cycles"}, 32'(nb), 32'(vecs[i].exp_busy));
      check({vecs[i].name, "_y"}, 32'(y), 32'(vecs[i].exp_y));
      check({vecs[i].name, "_c"}, 32'(c), 32'(vecs[i].exp_c));
      @(negedge clk);
      check({vecs[i].name, "_done_pulse"}, 32'(done), 32'h0);
      check({vecs[i].name, "_y_hold"}, 32'(y), 32'(vecs[i].exp_y));
    end

    // START during SHIFT is ignored.
    launch(8'h01, 1'b0, 2'b00, 4'd4, 1'b0);
    check("midstart_busy", 32'(busy), 32'h1);
    x     = 8'hFF;
    dir   = 1'b1;
    mode  = 2'b01;
    amt   = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(nb, seen);
    check("midstart_done_seen", 32'(seen), 32'h1);
    check("midstart_busy_cycles", 32'(nb + 1), 32'd4);
    check("midstart_y", 32'(y), 32'h10);
    check("midstart_c", 32'(c), 32'h0);
    @(negedge clk);

    // Back-to-back: START during DONE starts the next op with no IDLE gap.
    launch(8'hA0, 1'b1, 2'b10, 4'd2, 1'b0);
    wait_done(nb, seen);
    check("b2b_a_done_seen", 32'(seen), 32'h1);
    check("b2b_a_y", 32'(y), 32'hE8);
    launch(8'h81, 1'b0, 2'b01, 4'd1, 1'b0);
    check("b2b_b_busy_next", 32'(busy), 32'h1);
    check("b2b_b_no_done", 32'(done), 32'h0);
    @(negedge clk);
    check("b2b_b_done", 32'(done), 32'h1);
    check("b2b_b_y", 32'(y), 32'h02);
    check("b2b_b_c", 32'(c), 32'h1);
    @(negedge clk);

    // RESET during SHIFT discards the operation.
    launch(8'h96, 1'b1, 2'b00, 4'd3, 1'b0);
    check("rst_mid_busy_before", 32'(busy), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_y", 32'(y), 32'h0);
    check("rst_mid_c", 32'(c), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_done", 32'(done), 32'h0);
    any_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      any_done = any_done | done | busy;
    end
    check("rst_mid_quiet", 32'(any_done), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
